// File: rtl/instr_fetch.sv
// Instruction fetch initiator: sequential reads of instr_mem with one-cycle read latency,
// a small circular buffer toward decode, and redirect flushing of buffered and in-flight words.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | first cycle after reset release, nothing issued
// S_FETCH | normal issue whenever buffer + in-flight leave room
// S_REDIR | bubble cycle after a redirect, nothing issued
module instr_fetch #(
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              mem_ren_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int                PTR_W   = $clog2(BUF_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];
    logic [DATA_W-1:0] buf_data_d [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc_q   [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc_d   [BUF_DEPTH];

    logic              pop;
    logic              issue;
    logic              wr_en;
    logic [CNT_W-1:0]  occ;

    // Low address bits of the redirect target are dropped: fetches are word aligned.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc_i[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (redirect_i) state_d = S_REDIR;
            S_REDIR: state_d = redirect_i ? S_REDIR : S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // Occupancy after this edge counts the word arriving now; a new issue needs one more slot.
    always_comb begin
        pop       = instr_valid_o && instr_ready_i;
        occ       = count_q + CNT_W'(inflight_q) - CNT_W'(pop);
        issue     = (state_q == S_FETCH) && !redirect_i && (occ < DEPTH_C);
        wr_en     = inflight_q && !redirect_i;
        mem_ren_o = issue;
    end

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = buf_data_q[rd_ptr_q];
    assign pc_o          = buf_pc_q[rd_ptr_q];
    assign mem_addr_o    = fetch_pc_q;
    assign mem_wen_o     = 1'b0;
    assign mem_data_o    = '0;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        buf_data_d    = buf_data_q;
        buf_pc_d      = buf_pc_q;

        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        if (wr_en) begin
            buf_data_d[wr_ptr_q] = mem_rdata_i;
            buf_pc_d[wr_ptr_q]   = inflight_pc_q;
        end

        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            buf_data_q    <= buf_data_d;
            buf_pc_q      <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table plus hand sequences for
// redirect/transfer overlap, held redirect, redirect in IDLE and asynchronous reset.
module tb_instr_fetch;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect_i = 1'b0;
    logic [AW-1:0] redirect_pc_i = '0;
    logic          instr_valid_o;
    logic          instr_ready_i = 1'b0;
    logic [DW-1:0] instr_o;
    logic [AW-1:0] pc_o;
    logic          mem_ren_o;
    logic          mem_wen_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_rdata_i = '0;

    logic [DW-1:0] mem [256];

    instr_fetch #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RESET_PC ('0),
        .BUF_DEPTH(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .mem_ren_o    (mem_ren_o),
        .mem_wen_o    (mem_wen_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ren_o) mem_rdata_i <= mem[mem_addr_o[AW-1:2]];
    end

    typedef struct {
        logic          rdy;
        logic          redir;
        logic [AW-1:0] rpc;
        logic          ev;
        logic [AW-1:0] epc;
        logic [DW-1:0] einstr;
        logic          eren;
        logic [AW-1:0] eaddr;
    } vec_t;

    vec_t tv [28];

    int n_chk = 0;
    int n_err = 0;
    int seen10 = 0;
    int seen14 = 0;

    function automatic vec_t mk(input logic rdy, input logic redir, input logic [AW-1:0] rpc,
                                input logic ev, input logic [AW-1:0] epc, input logic [DW-1:0] ei,
                                input logic eren, input logic [AW-1:0] ea);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.einstr = ei; v.eren = eren; v.eaddr = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic d, input logic [AW-1:0] p);
        instr_ready_i = r;
        redirect_i    = d;
        redirect_pc_i = p;
        #1;
    endtask

    // Transfers are recorded from the settled outputs just before the edge that completes them.
    task automatic next_cyc();
        if (instr_valid_o && instr_ready_i) begin
            if (pc_o == 10'h010) seen10++;
            if (pc_o == 10'h014) seen14++;
        end
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [AW-1:0] epc,
                             input logic [DW-1:0] ei, input logic eren, input logic [AW-1:0] ea);
        chk({tag, " valid"}, 32'(instr_valid_o), 32'(ev));
        if (ev) begin
            chk({tag, " pc"}, 32'(pc_o), 32'(epc));
            chk({tag, " instr"}, instr_o, ei);
        end
        chk({tag, " ren"}, 32'(mem_ren_o), 32'(eren));
        chk({tag, " addr"}, 32'(mem_addr_o), 32'(ea));
        chk({tag, " wen"}, 32'(mem_wen_o), 32'd0);
        chk({tag, " wdata"}, mem_data_o, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            drive(tv[i].rdy, tv[i].redir, tv[i].rpc);
            check_out($sformatf("vec%0d", i), tv[i].ev, tv[i].epc, tv[i].einstr,
                      tv[i].eren, tv[i].eaddr);
            next_cyc();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;

        // cycle 0 is the first cycle after reset release (IDLE)
        tv[0]  = mk(1, 0, 10'h000, 0, 10'h000, 32'h000, 0, 10'h000);
        tv[1]  = mk(1, 0, 10'h000, 0, 10'h000, 32'h000, 1, 10'h000);
        tv[2]  = mk(1, 0, 10'h000, 0, 10'h000, 32'h000, 1, 10'h004);
        tv[3]  = mk(0, 0, 10'h000, 1, 10'h000, 32'h100, 0, 10'h008);
        tv[4]  = mk(0, 0, 10'h000, 1, 10'h000, 32'h100, 0, 10'h008);
        tv[5]  = mk(0, 0, 10'h000, 1, 10'h000, 32'h100, 0, 10'h008);
        tv[6]  = mk(0, 0, 10'h000, 1, 10'h000, 32'h100, 0, 10'h008);
        tv[7]  = mk(0, 0, 10'h000, 1, 10'h000, 32'h100, 0, 10'h008);
        tv[8]  = mk(1, 0, 10'h000, 1, 10'h000, 32'h100, 1, 10'h008);
        tv[9]  = mk(1, 0, 10'h000, 1, 10'h004, 32'h101, 1, 10'h00C);
        tv[10] = mk(1, 0, 10'h000, 1, 10'h008, 32'h102, 1, 10'h010);
        tv[11] = mk(0, 1, 10'h040, 1, 10'h00C, 32'h103, 0, 10'h014);
        tv[12] = mk(1, 0, 10'h000, 0, 10'h000, 32'h000, 0, 10'h040);
        tv[13] = mk(1, 0, 10'h000, 0, 10'h000, 32'h000, 1, 10'h040);
        tv[14] = mk(1, 0, 10'h000, 0, 10'h000, 32'h000, 1, 10'h044);
        tv[15] = mk(1, 0, 10'h000, 1, 10'h040, 32'h110, 1, 10'h048);
        tv[16] = mk(1, 1, 10'h043, 1, 10'h044, 32'h111, 0, 10'h04C);
        tv[17] = mk(1, 0, 10'h000, 0, 10'h000, 32'h000, 0, 10'h040);
        tv[18] = mk(1, 0, 10'h000, 0, 10'h000, 32'h000, 1, 10'h040);
        tv[19] = mk(1, 0, 10'h000, 0, 10'h000, 32'h000, 1, 10'h044);
        tv[20] = mk(1, 0, 10'h000, 1, 10'h040, 32'h110, 1, 10'h048);
        tv[21] = mk(1, 1, 10'h3F8, 1, 10'h044, 32'h111, 0, 10'h04C);
        tv[22] = mk(1, 0, 10'h000, 0, 10'h000, 32'h000, 0, 10'h3F8);
        tv[23] = mk(1, 0, 10'h000, 0, 10'h000, 32'h000, 1, 10'h3F8);
        tv[24] = mk(1, 0, 10'h000, 0, 10'h000, 32'h000, 1, 10'h3FC);
        tv[25] = mk(1, 0, 10'h000, 1, 10'h3F8, 32'h1FE, 1, 10'h000);
        tv[26] = mk(1, 0, 10'h000, 1, 10'h3FC, 32'h1FF, 1, 10'h004);
        tv[27] = mk(1, 0, 10'h000, 1, 10'h000, 32'h100, 1, 10'h008);

        #2;
        check_out("reset", 1'b0, '0, '0, 1'b0, 10'h000);
        chk("reset instr", instr_o, 32'd0);
        chk("reset pc", 32'(pc_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0, 27);

        // redirect in the same cycle decode takes pc 0x10
        do_reset();
        seen10 = 0;
        seen14 = 0;
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 1'b0, '0);
            if (k >= 3) begin
                chk($sformatf("stream%0d valid", k), 32'(instr_valid_o), 32'd1);
                chk($sformatf("stream%0d pc", k), 32'(pc_o), 32'((k - 3) * 4));
            end
            next_cyc();
        end
        drive(1'b1, 1'b1, 10'h080);
        check_out("xfer_redir", 1'b1, 10'h010, 32'h104, 1'b0, 10'h018);
        next_cyc();
        drive(1'b1, 1'b0, '0);
        check_out("xfer_redir+1", 1'b0, '0, '0, 1'b0, 10'h080);
        next_cyc();
        drive(1'b1, 1'b0, '0);
        check_out("xfer_redir+2", 1'b0, '0, '0, 1'b1, 10'h080);
        next_cyc();
        drive(1'b1, 1'b0, '0);
        check_out("xfer_redir+3", 1'b0, '0, '0, 1'b1, 10'h084);
        next_cyc();
        drive(1'b1, 1'b0, '0);
        check_out("xfer_redir+4", 1'b1, 10'h080, 32'h120, 1'b1, 10'h088);
        next_cyc();
        chk("pc10 consumed once", seen10, 1);
        chk("pc14 never delivered", seen14, 0);

        // asynchronous reset with a read in flight
        drive(1'b1, 1'b0, '0);
        chk("pre_rst ren", 32'(mem_ren_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, '0, '0, 1'b0, 10'h000);
        chk("async_rst instr", instr_o, 32'd0);
        chk("async_rst pc", 32'(pc_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0, 4);

        // redirect held two cycles: the last target wins
        drive(1'b1, 1'b1, 10'h100);
        chk("hold0 valid", 32'(instr_valid_o), 32'd1);
        chk("hold0 ren", 32'(mem_ren_o), 32'd0);
        next_cyc();
        drive(1'b1, 1'b1, 10'h206);
        check_out("hold1", 1'b0, '0, '0, 1'b0, 10'h100);
        next_cyc();
        drive(1'b1, 1'b0, '0);
        check_out("hold2", 1'b0, '0, '0, 1'b0, 10'h204);
        next_cyc();
        drive(1'b1, 1'b0, '0);
        check_out("hold3", 1'b0, '0, '0, 1'b1, 10'h204);
        next_cyc();
        drive(1'b1, 1'b0, '0);
        check_out("hold4", 1'b0, '0, '0, 1'b1, 10'h208);
        next_cyc();
        drive(1'b1, 1'b0, '0);
        check_out("hold5", 1'b1, 10'h204, 32'h181, 1'b1, 10'h20C);
        next_cyc();

        // redirect during IDLE is latched, state still proceeds to FETCH
        do_reset();
        drive(1'b1, 1'b1, 10'h022);
        check_out("idle_redir0", 1'b0, '0, '0, 1'b0, 10'h000);
        next_cyc();
        drive(1'b1, 1'b0, '0);
        check_out("idle_redir1", 1'b0, '0, '0, 1'b1, 10'h020);
        next_cyc();
        drive(1'b1, 1'b0, '0);
        check_out("idle_redir2", 1'b0, '0, '0, 1'b1, 10'h024);
        next_cyc();
        drive(1'b1, 1'b0, '0);
        check_out("idle_redir3", 1'b1, 10'h020, 32'h108, 1'b1, 10'h028);
        next_cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
